// File: rtl/dma_eng_pkg.sv
// ============================================================================
// dma_eng_pkg : shared types and field offsets for the FPGA-to-host DMA engine
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dma_eng_pkg;

    localparam int CMD_W        = 160;
    localparam int CMD_LEN_LSB  = 0;
    localparam int CMD_OFS_LSB  = 32;
    localparam int CMD_ADDR_LSB = 96;

    localparam int CTRL_BASE_LO = 0;
    localparam int CTRL_BASE_HI = 1;
    localparam int CTRL_CFG     = 4;
    localparam int CFG_ENABLE   = 0;
    localparam int CFG_CLEAR    = 1;

    localparam int STS_CMDS_DONE   = 0;
    localparam int STS_CHUNKS_DONE = 1;
    localparam int STS_DROPS       = 2;
    localparam int STS_BUSY        = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CALC  = 3'd2,
        ISSUE = 3'd3,
        NEXT  = 3'd4
    } state_e;

    typedef struct packed {
        logic        eoc;
        logic [31:0] len;
    } track_entry_t;

endpackage

`default_nettype wire

// File: rtl/blockram_fifo.sv
// ============================================================================
// blockram_fifo : show-ahead synchronous FIFO with an almost-full flag
// Revision      : 1.0
// ============================================================================
`default_nettype none

module blockram_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_BITS = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             almostfull_o
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int CNT_W = DEPTH_BITS + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  full, do_push, do_pop;

    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty_o      = (count_q == '0);
    // Two-entry margin so an upstream with one cycle of ready latency cannot overflow
    assign almostfull_o = (count_q >= CNT_W'(DEPTH - 2));
    assign do_push      = push_i & ~full;
    assign do_pop       = pop_i & ~empty_o;
    assign dout_o       = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_chunk_tracker.sv
// ============================================================================
// dma_chunk_tracker : in-flight chunk FIFO and per-chunk last/keep generation
// Revision          : 1.0
// ============================================================================
`default_nettype none

module dma_chunk_tracker
    import dma_eng_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 8,
    localparam int KEEP_W         = DATA_WIDTH / 8,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push_i,
    input  track_entry_t          push_entry_i,
    output logic                  full_o,
    output logic [CNT_W-1:0]      count_o,
    input  logic                  src_tvalid_i,
    output logic                  src_tready_o,
    input  logic [DATA_WIDTH-1:0] src_tdata_i,
    input  logic [KEEP_W-1:0]     src_tkeep_i,
    output logic                  dst_tvalid_o,
    input  logic                  dst_tready_i,
    output logic [DATA_WIDTH-1:0] dst_tdata_o,
    output logic [KEEP_W-1:0]     dst_tkeep_o,
    output logic                  dst_tlast_o,
    output logic                  chunk_done_o,
    output logic                  cmd_done_o
);

    localparam int PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int BPB_BITS = $clog2(KEEP_W);

    track_entry_t     fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      beat_q;

    track_entry_t        head;
    logic                nonempty, is_last, beat_hs, pop;
    logic [31:0]         last_idx;
    logic [BPB_BITS-1:0] tail_bytes;
    logic [KEEP_W-1:0]   last_keep;

    assign head       = fifo_q[rd_ptr_q];
    assign nonempty   = (count_q != '0);
    assign full_o     = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign count_o    = count_q;
    // Chunk lengths are never zero, so len-1 cannot underflow
    assign last_idx   = (head.len - 32'd1) >> BPB_BITS;
    assign is_last    = (beat_q == last_idx);
    assign tail_bytes = head.len[BPB_BITS-1:0];
    assign last_keep  = (tail_bytes == '0) ? '1
                      : ((KEEP_W'(1) << tail_bytes) - KEEP_W'(1));

    assign dst_tvalid_o = src_tvalid_i & nonempty;
    assign src_tready_o = dst_tready_i & nonempty;
    assign dst_tdata_o  = src_tdata_i;
    assign dst_tkeep_o  = is_last ? last_keep : src_tkeep_i;
    assign dst_tlast_o  = nonempty & is_last;

    assign beat_hs      = src_tvalid_i & dst_tready_i & nonempty;
    assign pop          = beat_hs & is_last;
    assign chunk_done_o = pop;
    assign cmd_done_o   = pop & head.eoc;

    always_ff @(posedge clk) begin
        if (push_i) fifo_q[wr_ptr_q] <= push_entry_i;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                beat_q   <= '0;
            end else if (beat_hs) begin
                beat_q   <= beat_q + 32'd1;
            end
            case ({push_i, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_fpga_to_host_engine.sv
// ============================================================================
// dma_fpga_to_host_engine : splits get-data commands into host-aligned chunks
//                           and forwards memory read data to the host stream
// Revision                : 1.0
// ============================================================================
`default_nettype none

module dma_fpga_to_host_engine
    import dma_eng_pkg::*;
#(
    parameter int DATA_WIDTH          = 512,
    parameter int MAX_CHUNK           = 4096,
    parameter int MAX_OUTSTANDING     = 8,
    parameter int CMD_FIFO_DEPTH_BITS = 9,
    localparam int KEEP_W             = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_axis_get_data_cmd_valid_i,
    output logic                  s_axis_get_data_cmd_ready_o,
    input  logic [CMD_W-1:0]      s_axis_get_data_cmd_data_i,
    output logic                  m_axis_mem_read_cmd_valid_o,
    input  logic                  m_axis_mem_read_cmd_ready_i,
    output logic [63:0]           m_axis_mem_read_cmd_addr_o,
    output logic [31:0]           m_axis_mem_read_cmd_len_o,
    input  logic                  s_axis_mem_read_sts_valid_i,
    output logic                  s_axis_mem_read_sts_ready_o,
    input  logic [7:0]            s_axis_mem_read_sts_data_i,
    input  logic                  s_axis_mem_read_data_tvalid_i,
    output logic                  s_axis_mem_read_data_tready_o,
    input  logic [DATA_WIDTH-1:0] s_axis_mem_read_data_tdata_i,
    input  logic [KEEP_W-1:0]     s_axis_mem_read_data_tkeep_i,
    input  logic                  s_axis_mem_read_data_tlast_i,
    output logic                  axis_dma_write_cmd_valid_o,
    input  logic                  axis_dma_write_cmd_ready_i,
    output logic [63:0]           axis_dma_write_cmd_addr_o,
    output logic [31:0]           axis_dma_write_cmd_len_o,
    output logic                  axis_dma_write_data_tvalid_o,
    input  logic                  axis_dma_write_data_tready_i,
    output logic [DATA_WIDTH-1:0] axis_dma_write_data_tdata_o,
    output logic [KEEP_W-1:0]     axis_dma_write_data_tkeep_o,
    output logic                  axis_dma_write_data_tlast_o,
    input  logic [15:0][31:0]     control_reg_i,
    output logic [3:0][31:0]      status_reg_o
);

    localparam int CHUNK_BITS = $clog2(MAX_CHUNK);
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING) + 1;

    state_e       state_q;
    logic [CMD_W-1:0] cmd_q;
    logic [63:0]  host_addr_q, mem_addr_q;
    logic [31:0]  rem_len_q, chunk_q;
    logic         mem_valid_q, dma_valid_q, mem_acc_q, dma_acc_q, issued_q;
    logic [31:0]  cmd_cnt_q, chunk_cnt_q, drop_cnt_q;

    logic             fifo_empty, fifo_afull, fifo_pop;
    logic [CMD_W-1:0] fifo_dout;
    logic             enable, clear, busy, drop_inc;
    logic [63:0]      host_base;
    logic [31:0]      chunk_space, chunk_calc;
    logic             mem_ok, dma_ok, trk_push, trk_full, chunk_done, cmd_done;
    logic [OUT_W-1:0] trk_count;
    track_entry_t     trk_entry;
    logic             unused_ok;

    assign enable    = control_reg_i[CTRL_CFG][CFG_ENABLE];
    assign clear     = control_reg_i[CTRL_CFG][CFG_CLEAR];
    assign host_base = {control_reg_i[CTRL_BASE_HI], control_reg_i[CTRL_BASE_LO]};

    // The FIFO's flags are meaningless in reset, so ready is also gated by rstn
    assign s_axis_get_data_cmd_ready_o = ~fifo_afull & rstn;
    assign s_axis_mem_read_sts_ready_o = 1'b1;
    assign fifo_pop = (state_q == IDLE) & ~fifo_empty & enable;

    blockram_fifo #(
        .WIDTH      (CMD_W),
        .DEPTH_BITS (CMD_FIFO_DEPTH_BITS)
    ) u_cmd_fifo (
        .clk          (clk),
        .rstn         (rstn),
        .push_i       (s_axis_get_data_cmd_valid_i & s_axis_get_data_cmd_ready_o),
        .din_i        (s_axis_get_data_cmd_data_i),
        .pop_i        (fifo_pop),
        .dout_o       (fifo_dout),
        .empty_o      (fifo_empty),
        .almostfull_o (fifo_afull)
    );

    assign chunk_space = 32'(MAX_CHUNK) - 32'(host_addr_q[CHUNK_BITS-1:0]);
    assign chunk_calc  = (rem_len_q < chunk_space) ? rem_len_q : chunk_space;

    assign mem_ok    = mem_acc_q | (mem_valid_q & m_axis_mem_read_cmd_ready_i);
    assign dma_ok    = dma_acc_q | (dma_valid_q & axis_dma_write_cmd_ready_i);
    assign trk_push  = (state_q == ISSUE) & issued_q & mem_ok & dma_ok;
    assign trk_entry = '{eoc: (chunk_q == rem_len_q), len: chunk_q};
    assign drop_inc  = (state_q == LOAD) & (cmd_q[CMD_LEN_LSB +: 32] == 32'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            host_addr_q <= '0;
            mem_addr_q  <= '0;
            rem_len_q   <= '0;
            chunk_q     <= '0;
            mem_valid_q <= 1'b0;
            dma_valid_q <= 1'b0;
            mem_acc_q   <= 1'b0;
            dma_acc_q   <= 1'b0;
            issued_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        cmd_q   <= fifo_dout;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    rem_len_q   <= cmd_q[CMD_LEN_LSB +: 32];
                    host_addr_q <= host_base + cmd_q[CMD_OFS_LSB +: 64];
                    mem_addr_q  <= cmd_q[CMD_ADDR_LSB +: 64];
                    state_q     <= drop_inc ? IDLE : CALC;
                end
                CALC: begin
                    chunk_q   <= chunk_calc;
                    issued_q  <= 1'b0;
                    mem_acc_q <= 1'b0;
                    dma_acc_q <= 1'b0;
                    state_q   <= ISSUE;
                end
                ISSUE: begin
                    if (!issued_q) begin
                        if (!trk_full) begin
                            mem_valid_q <= 1'b1;
                            dma_valid_q <= 1'b1;
                            issued_q    <= 1'b1;
                        end
                    end else begin
                        if (mem_valid_q && m_axis_mem_read_cmd_ready_i) begin
                            mem_valid_q <= 1'b0;
                            mem_acc_q   <= 1'b1;
                        end
                        if (dma_valid_q && axis_dma_write_cmd_ready_i) begin
                            dma_valid_q <= 1'b0;
                            dma_acc_q   <= 1'b1;
                        end
                        if (trk_push) state_q <= NEXT;
                    end
                end
                NEXT: begin
                    host_addr_q <= host_addr_q + 64'(chunk_q);
                    mem_addr_q  <= mem_addr_q + 64'(chunk_q);
                    rem_len_q   <= rem_len_q - chunk_q;
                    state_q     <= (rem_len_q == chunk_q) ? IDLE : CALC;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_cnt_q   <= '0;
            chunk_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (clear) begin
            cmd_cnt_q   <= '0;
            chunk_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (cmd_done)   cmd_cnt_q   <= cmd_cnt_q + 32'd1;
            if (chunk_done) chunk_cnt_q <= chunk_cnt_q + 32'd1;
            if (drop_inc)   drop_cnt_q  <= drop_cnt_q + 32'd1;
        end
    end

    dma_chunk_tracker #(
        .DATA_WIDTH      (DATA_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_tracker (
        .clk          (clk),
        .rstn         (rstn),
        .push_i       (trk_push),
        .push_entry_i (trk_entry),
        .full_o       (trk_full),
        .count_o      (trk_count),
        .src_tvalid_i (s_axis_mem_read_data_tvalid_i),
        .src_tready_o (s_axis_mem_read_data_tready_o),
        .src_tdata_i  (s_axis_mem_read_data_tdata_i),
        .src_tkeep_i  (s_axis_mem_read_data_tkeep_i),
        .dst_tvalid_o (axis_dma_write_data_tvalid_o),
        .dst_tready_i (axis_dma_write_data_tready_i),
        .dst_tdata_o  (axis_dma_write_data_tdata_o),
        .dst_tkeep_o  (axis_dma_write_data_tkeep_o),
        .dst_tlast_o  (axis_dma_write_data_tlast_o),
        .chunk_done_o (chunk_done),
        .cmd_done_o   (cmd_done)
    );

    assign m_axis_mem_read_cmd_valid_o = mem_valid_q;
    assign m_axis_mem_read_cmd_addr_o  = mem_addr_q;
    assign m_axis_mem_read_cmd_len_o   = chunk_q;
    assign axis_dma_write_cmd_valid_o  = dma_valid_q;
    assign axis_dma_write_cmd_addr_o   = host_addr_q;
    assign axis_dma_write_cmd_len_o    = chunk_q;

    assign busy = (state_q != IDLE) | (trk_count != '0);
    assign status_reg_o[STS_CMDS_DONE]   = cmd_cnt_q;
    assign status_reg_o[STS_CHUNKS_DONE] = chunk_cnt_q;
    assign status_reg_o[STS_DROPS]       = drop_cnt_q;
    assign status_reg_o[STS_BUSY]        = {busy, 15'b0, 16'(trk_count)};

    // Read status and source tlast carry nothing this engine acts on
    assign unused_ok = ^{s_axis_mem_read_sts_valid_i, s_axis_mem_read_sts_data_i,
                         s_axis_mem_read_data_tlast_i, control_reg_i[15:5],
                         control_reg_i[3:2], control_reg_i[CTRL_CFG][31:2]};

endmodule

`default_nettype wire

// File: tb/tb_dma_fpga_to_host_engine.sv
// ============================================================================
// tb_dma_fpga_to_host_engine : scoreboard bench for the FPGA-to-host DMA engine
// Revision                   : 1.0
// ============================================================================
`default_nettype none

module tb_dma_fpga_to_host_engine;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam logic [63:0] BASE = 64'h0000_0001_0000_0000;

    typedef struct {logic [63:0] addr; logic [31:0] len;} cmd_t;
    typedef struct {logic last; logic [KW-1:0] keep; logic [31:0] idx;} beat_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [159:0]    cmd_data = '0;
    logic            mc_valid, mc_ready = 1'b1;
    logic [63:0]     mc_addr;
    logic [31:0]     mc_len;
    logic            sts_ready;
    logic            src_tready;
    logic [31:0]     src_idx;
    logic            dc_valid, dc_ready = 1'b1;
    logic [63:0]     dc_addr;
    logic [31:0]     dc_len;
    logic            dd_valid, dd_ready = 1'b1, dd_last;
    logic [DW-1:0]   dd_data;
    logic [KW-1:0]   dd_keep;
    logic [15:0][31:0] ctrl = '0;
    logic [3:0][31:0]  status;

    cmd_t  mem_q[$], dma_q[$];
    beat_t beat_q[$];
    cmd_t  m_e, d_e;
    beat_t b_e;
    int    n_cmp = 0, n_err = 0;
    int    exp_idx = 0;

    always #5 clk = ~clk;

    dma_fpga_to_host_engine #(
        .DATA_WIDTH(DW), .MAX_CHUNK(4096), .MAX_OUTSTANDING(8), .CMD_FIFO_DEPTH_BITS(9)
    ) dut (
        .clk                           (clk),
        .rstn                          (rstn),
        .s_axis_get_data_cmd_valid_i   (cmd_valid),
        .s_axis_get_data_cmd_ready_o   (cmd_ready),
        .s_axis_get_data_cmd_data_i    (cmd_data),
        .m_axis_mem_read_cmd_valid_o   (mc_valid),
        .m_axis_mem_read_cmd_ready_i   (mc_ready),
        .m_axis_mem_read_cmd_addr_o    (mc_addr),
        .m_axis_mem_read_cmd_len_o     (mc_len),
        .s_axis_mem_read_sts_valid_i   (1'b0),
        .s_axis_mem_read_sts_ready_o   (sts_ready),
        .s_axis_mem_read_sts_data_i    (8'h00),
        .s_axis_mem_read_data_tvalid_i (1'b1),
        .s_axis_mem_read_data_tready_o (src_tready),
        .s_axis_mem_read_data_tdata_i  ({16{src_idx}}),
        .s_axis_mem_read_data_tkeep_i  ({KW{1'b1}}),
        .s_axis_mem_read_data_tlast_i  (1'b0),
        .axis_dma_write_cmd_valid_o    (dc_valid),
        .axis_dma_write_cmd_ready_i    (dc_ready),
        .axis_dma_write_cmd_addr_o     (dc_addr),
        .axis_dma_write_cmd_len_o      (dc_len),
        .axis_dma_write_data_tvalid_o  (dd_valid),
        .axis_dma_write_data_tready_i  (dd_ready),
        .axis_dma_write_data_tdata_o   (dd_data),
        .axis_dma_write_data_tkeep_o   (dd_keep),
        .axis_dma_write_data_tlast_o   (dd_last),
        .control_reg_i                 (ctrl),
        .status_reg_o                  (status)
    );

    // Memory-side source: always-valid beats carrying a running index
    always @(posedge clk or negedge rstn) begin
        if (!rstn) src_idx <= '0;
        else if (src_tready) src_idx <= src_idx + 32'd1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event expected none", name);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (mc_valid && mc_ready) begin
                if (mem_q.size() == 0) flag("mem_cmd_unexpected");
                else begin
                    m_e = mem_q.pop_front();
                    check("mem_cmd", {32'b0, mc_addr, mc_len}, {32'b0, m_e.addr, m_e.len});
                end
            end
            if (dc_valid && dc_ready) begin
                if (dma_q.size() == 0) flag("dma_cmd_unexpected");
                else begin
                    d_e = dma_q.pop_front();
                    check("dma_cmd", {32'b0, dc_addr, dc_len}, {32'b0, d_e.addr, d_e.len});
                end
            end
            if (dd_valid && dd_ready) begin
                if (beat_q.size() == 0) flag("beat_unexpected");
                else begin
                    b_e = beat_q.pop_front();
                    check("beat", {31'b0, dd_last, dd_keep, dd_data[31:0]},
                                  {31'b0, b_e.last, b_e.keep, b_e.idx});
                end
            end
        end
    end

    task automatic expect_chunk(input logic [63:0] mem, input logic [63:0] host, input int len);
        int nb;
        beat_t b;
        mem_q.push_back('{addr: mem, len: 32'(len)});
        dma_q.push_back('{addr: host, len: 32'(len)});
        nb = (len + KW - 1) / KW;
        for (int i = 0; i < nb; i++) begin
            b.last = (i == nb - 1);
            b.keep = (b.last && (len % KW) != 0) ? ((KW'(1) << (len % KW)) - KW'(1)) : {KW{1'b1}};
            b.idx  = 32'(exp_idx);
            exp_idx++;
            beat_q.push_back(b);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] len, input logic [63:0] ofs, input logic [63:0] mem);
        bit done = 0;
        cmd_data  = {mem, ofs, len};
        cmd_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!done) flag("cmd_accept_timeout");
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        cycles(4);
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            ok = !status[3][31] && mem_q.size() == 0 && dma_q.size() == 0 && beat_q.size() == 0;
        end
        if (!ok) flag("idle_timeout");
        cycles(1);
    endtask

    task automatic clear_counters();
        ctrl[4][1] = 1'b1;
        cycles(1);
        ctrl[4][1] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl[0] = BASE[31:0];
        ctrl[1] = BASE[63:32];
        ctrl[4] = 32'h1;
        cycles(3);
        check("rst_cmd_ready", 128'(cmd_ready), 128'(0));
        check("rst_valids", 128'({mc_valid, dc_valid, dd_valid}), 128'(0));
        check("rst_status", 128'(status), 128'(0));
        rstn = 1'b1;
        cycles(2);

        // Single aligned 256-byte command
        expect_chunk(64'h1000, BASE, 256);
        send_cmd(256, 64'h0, 64'h1000);
        wait_idle(500);
        check("t1_cmds", 128'(status[0]), 128'(1));
        check("t1_chunks", 128'(status[1]), 128'(1));

        // 10000 bytes from offset 0xF00: four chunks split on 4 KB host boundaries
        clear_counters();
        expect_chunk(64'h20000, BASE + 64'h0F00, 256);
        expect_chunk(64'h20100, BASE + 64'h1000, 4096);
        expect_chunk(64'h21100, BASE + 64'h2000, 4096);
        expect_chunk(64'h22100, BASE + 64'h3000, 1552);
        send_cmd(10000, 64'h0F00, 64'h20000);
        wait_idle(2000);
        check("t2_cmds", 128'(status[0]), 128'(1));
        check("t2_chunks", 128'(status[1]), 128'(4));

        // Zero-length command is dropped, the following one runs
        clear_counters();
        send_cmd(0, 64'h80, 64'h5000);
        expect_chunk(64'h3000, BASE + 64'h40, 64);
        send_cmd(64, 64'h40, 64'h3000);
        wait_idle(500);
        check("t3_drops", 128'(status[2]), 128'(1));
        check("t3_cmds", 128'(status[0]), 128'(1));
        check("t3_chunks", 128'(status[1]), 128'(1));

        // Host write command stalled: memory command accepted once, FSM waits in ISSUE
        clear_counters();
        dc_ready = 1'b0;
        expect_chunk(64'h4000, BASE + 64'h200, 128);
        send_cmd(128, 64'h200, 64'h4000);
        cycles(20);
        check("t4_mem_left", 128'(mem_q.size()), 128'(0));
        check("t4_dma_left", 128'(dma_q.size()), 128'(1));
        check("t4_dma_valid", 128'(dc_valid), 128'(1));
        check("t4_busy", 128'(status[3]), 128'(32'h8000_0000));
        dc_ready = 1'b1;
        wait_idle(500);
        check("t4_chunks", 128'(status[1]), 128'(1));

        // Twelve 4 KB chunks with the data sink stalled: issue stops at 8 outstanding
        clear_counters();
        dd_ready = 1'b0;
        for (int i = 0; i < 12; i++)
            expect_chunk(64'h10_0000 + 64'(i * 4096), BASE + 64'h1_0000 + 64'(i * 4096), 4096);
        send_cmd(49152, 64'h1_0000, 64'h10_0000);
        cycles(60);
        check("t5_outstanding", 128'(status[3]), 128'(32'h8000_0008));
        check("t5_mem_left", 128'(mem_q.size()), 128'(4));
        dd_ready = 1'b1;
        wait_idle(3000);
        check("t5_chunks", 128'(status[1]), 128'(12));
        check("t5_cmds", 128'(status[0]), 128'(1));

        // Asynchronous reset in the middle of a data transfer
        clear_counters();
        expect_chunk(64'h8000, BASE, 4096);
        send_cmd(4096, 64'h0, 64'h8000);
        cycles(15);
        check("t6_pre_valid", 128'(dd_valid), 128'(1));
        #2 rstn = 1'b0;
        #1;
        check("t6_async_valids", 128'({mc_valid, dc_valid, dd_valid}), 128'(0));
        check("t6_async_ready", 128'(cmd_ready), 128'(0));
        mem_q.delete();
        dma_q.delete();
        beat_q.delete();
        exp_idx = 0;
        cycles(3);
        rstn = 1'b1;
        cycles(2);
        check("t6_status", 128'(status), 128'(0));
        expect_chunk(64'h9000, BASE + 64'h100, 256);
        send_cmd(256, 64'h100, 64'h9000);
        wait_idle(500);
        check("t6_cmds", 128'(status[0]), 128'(1));
        check("t6_chunks", 128'(status[1]), 128'(1));

        check("end_mem_q", 128'(mem_q.size()), 128'(0));
        check("end_dma_q", 128'(dma_q.size()), 128'(0));
        check("end_beat_q", 128'(beat_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
